lap_store: RTL and testbench
============================

# lap_store

Lap-time storage bank for the stopwatch, directly downstream of the control FSM and stopwatch counter. On the FSM's SAVE state it captures the packed `{hour, minute, second, m_sec}` epoch into a small circular memory. On RETRIEVE it presents stored laps oldest-first to the BCD conversion/display path. On CLEAR it wipes the bank. It produces the `reg_busy` handshake that the control FSM consumes.

## Interface
- `DEPTH`, 8: number of lap entries; power of two, ≥ 2.
- `WIDTH`, 28: entry width; packs `{hour[5:0], minute[5:0], second[5:0], m_sec[9:0]}`.
- `clock` in 1: system clock (`clock_50m` at top).
- `reset_n` in 1: reset, asynchronous, active-low.
- `save` in 1: write request; level sampled each edge (FSM SAVE state).
- `retrieve` in 1: read-next request (FSM RETRIEVE state).
- `clear` in 1: wipe request (FSM CLEAR state).
- `time_in` in WIDTH: current stopwatch epoch.
- `busy` out 1: operation in progress; drives `reg_busy`.
- `lap_out` out WIDTH: last retrieved lap.
- `out_valid` out 1: one-cycle pulse when `lap_out` updates.
- `lap_index` out clog2(DEPTH)+1: 1-based number of the lap on `lap_out`; 0 = none.
- `count` out clog2(DEPTH)+1: number of stored laps, 0..DEPTH.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.

## Operation
- Reset values: `busy`=0, `lap_out`=0, `out_valid`=0, `lap_index`=0, `count`=0, `empty`=1, `full`=0. Write, oldest and read pointers are 0. Memory contents are don't-care until written.
- States are IDLE, WRITE, READ_ADDR, READ_DATA and CLEAR. Only IDLE accepts requests.
- Priority when requests coincide: `clear` > `save` > `retrieve`. Requests arriving while `busy`=1 are dropped, not queued.
- IDLE → WRITE on `save`:
  - `time_in` is latched at the sampling edge.
  - In WRITE, the memory at `wr_ptr` is written, `wr_ptr` increments (wraps at DEPTH) and `count` increments.
  - The FSM then returns to IDLE.
- Save when full, without the macro: the request is ignored and the FSM stays in IDLE with `busy`=0.
- IDLE → READ_ADDR on `retrieve` when not empty:
  - READ_ADDR issues `oldest_ptr + rd_off`.
  - READ_DATA registers the data into `lap_out`, sets `lap_index = rd_off+1` and pulses `out_valid`.
  - `rd_off` increments and wraps to 0 after `count-1`, so lap display cycles oldest→newest→oldest.
- Retrieve when empty: ignored. No busy, no `out_valid`, outputs unchanged.
- IDLE → CLEAR on `clear`:
  - The FSM walks addresses 0..DEPTH-1 writing zeros, one per cycle.
  - On exit, all pointers, `count`, `lap_out` and `lap_index` are 0.
- Saving does not reset `rd_off`. A newly saved lap is reached in order.
- Asserting `reset_n` low mid-operation aborts immediately to the reset values. A partial clear or write has no further effect.

## Timing
- Request sampled at edge N in IDLE; `busy` rises after edge N.
- Save: `busy` is high for exactly 1 cycle. The memory write and the `count`/`full`/`empty` update are visible after edge N+1.
- Retrieve: `busy` is high for 2 cycles. `lap_out`, `lap_index` and `out_valid` update after edge N+2, and `busy` falls at the same edge.
- Clear: `busy` is high for DEPTH cycles. State is zeroed after edge N+DEPTH.
- `full`/`empty` are registered and change in the same cycle as `count`.
- Back-to-back operations are allowed: a new request may be sampled at the edge on which `busy` falls.

## Configuration
- `LAP_OVERWRITE_EN` defined: saving while full overwrites the oldest entry.
  - `wr_ptr` and `oldest_ptr` both advance; `count` stays at DEPTH.
  - `rd_off` resets to 0, so the next retrieve shows the new oldest entry.
  - Timing is the same as a normal save.
- `LAP_OVERWRITE_EN` undefined: saving while full is ignored, as described in Operation.

## Test plan
- Reset, then retrieve: no `busy`, no `out_valid`; `lap_out`=0, `empty`=1.
- Save three epochs A=0x0000001, B=0x0041064, C=0x3FFFFFF, then retrieve four times: `lap_out` = A, B, C, A with `lap_index` = 1, 2, 3, 1. Each `out_valid` arrives 2 cycles after its request; `count`=3.
- Save and retrieve asserted in the same cycle: only the save occurs (`busy` high 1 cycle). A later retrieve returns the saved value.
- DEPTH=8, nine saves of values 1..9:
  - Macro undefined: `full`=1, `count`=8, ninth save ignored, first retrieve shows 1.
  - Macro defined: first retrieve shows 2; retrieves 8 and 9 show 9 and 2.
- Clear while holding 5 laps: `busy` high exactly 8 cycles. A save asserted during clear is dropped. Afterwards `count`=0, `empty`=1, `lap_out`=0, `lap_index`=0.
- `reset_n` pulsed low during cycle 3 of a clear: all outputs return to reset values asynchronously. A subsequent save followed by a retrieve returns the saved value with `lap_index`=1.

Source files
------------

// File: rtl/lap_store.sv
// Lap-time storage bank: circular memory of stopwatch epochs with save, retrieve and clear.
// Optional build macro LAP_OVERWRITE_EN: saving while full replaces the oldest lap.
module lap_store #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 28
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     save,
    input  logic                     retrieve,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         time_in,
    output logic                     busy,
    output logic [WIDTH-1:0]         lap_out,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   lap_index,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ADDR,
        READ_DATA,
        CLEAR
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    oldestPtr_q;
    logic [AW-1:0]    rdOff_q;
    logic [AW-1:0]    rdAddr_q;
    logic [AW-1:0]    clrAddr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    lapIndex_q;
    logic [WIDTH-1:0] timeLatch_q;
    logic [WIDTH-1:0] lapOut_q;
    logic             busy_q;
    logic             outValid_q;
    logic             full_q;
    logic             empty_q;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    countInc_d;
    logic [AW-1:0]    rdOffNext_d;
    logic             saveAccept_d;
    logic             memWe_d;
    logic [AW-1:0]    memAddr_d;
    logic [WIDTH-1:0] memData_d;

    // Read offset wraps after the newest stored lap so display cycles oldest to newest.
    always_comb begin
        countInc_d  = count_q + CW'(1);
        rdOffNext_d = ({1'b0, rdOff_q} == (count_q - CW'(1))) ? '0 : rdOff_q + AW'(1);
`ifdef LAP_OVERWRITE_EN
        saveAccept_d = 1'b1;
`else
        saveAccept_d = !full_q;
`endif
        memWe_d   = 1'b0;
        memAddr_d = wrPtr_q;
        memData_d = timeLatch_q;
        if (state_q == WRITE) begin
            memWe_d = 1'b1;
        end else if (state_q == CLEAR) begin
            memWe_d   = 1'b1;
            memAddr_d = clrAddr_q;
            memData_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (memWe_d) begin
            mem_q[memAddr_d] <= memData_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            oldestPtr_q <= '0;
            rdOff_q     <= '0;
            rdAddr_q    <= '0;
            clrAddr_q   <= '0;
            count_q     <= '0;
            lapIndex_q  <= '0;
            timeLatch_q <= '0;
            lapOut_q    <= '0;
            busy_q      <= 1'b0;
            outValid_q  <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            outValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        clrAddr_q <= '0;
                    end else if (save) begin
                        if (saveAccept_d) begin
                            state_q     <= WRITE;
                            busy_q      <= 1'b1;
                            timeLatch_q <= time_in;
                        end
                    end else if (retrieve && !empty_q) begin
                        state_q <= READ_ADDR;
                        busy_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    wrPtr_q <= wrPtr_q + AW'(1);
                    // A write while full can only happen in overwrite builds.
                    if (full_q) begin
                        oldestPtr_q <= oldestPtr_q + AW'(1);
                        rdOff_q     <= '0;
                    end else begin
                        count_q <= countInc_d;
                        full_q  <= (countInc_d == CW'(DEPTH));
                        empty_q <= 1'b0;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                READ_ADDR: begin
                    rdAddr_q <= oldestPtr_q + rdOff_q;
                    state_q  <= READ_DATA;
                end
                READ_DATA: begin
                    lapOut_q   <= mem_q[rdAddr_q];
                    lapIndex_q <= {1'b0, rdOff_q} + CW'(1);
                    outValid_q <= 1'b1;
                    rdOff_q    <= rdOffNext_d;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                CLEAR: begin
                    clrAddr_q <= clrAddr_q + AW'(1);
                    if (clrAddr_q == AW'(DEPTH - 1)) begin
                        wrPtr_q     <= '0;
                        oldestPtr_q <= '0;
                        rdOff_q     <= '0;
                        count_q     <= '0;
                        lapOut_q    <= '0;
                        lapIndex_q  <= '0;
                        full_q      <= 1'b0;
                        empty_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign lap_out   = lapOut_q;
    assign out_valid = outValid_q;
    assign lap_index = lapIndex_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_lap_store.sv
// Self-checking bench for lap_store: table of operations plus hand-written corner sequences,
// with a scoreboard queue holding the laps expected on each out_valid pulse.
module tb_lap_store;

   localparam int DEPTH = 8;
   localparam int WIDTH = 28;
   localparam int CW    = 4;

   logic             clock;
   logic             reset_n;
   logic             save;
   logic             retrieve;
   logic             clear;
   logic [WIDTH-1:0] time_in;
   logic             busy;
   logic [WIDTH-1:0] lap_out;
   logic             out_valid;
   logic [CW-1:0]    lap_index;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic             s;
      logic             r;
      logic             c;
      logic [WIDTH-1:0] t;
      int               expBusy;
      int               expCount;
      logic             expEmpty;
      logic             expFull;
      logic             expValid;
      logic [WIDTH-1:0] expLap;
      int               expIdx;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] lap;
      logic [CW-1:0]    idx;
      int               due;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[$];

   lap_store #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .save      (save),
      .retrieve  (retrieve),
      .clear     (clear),
      .time_in   (time_in),
      .busy      (busy),
      .lap_out   (lap_out),
      .out_valid (out_valid),
      .lap_index (lap_index),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Free-running 100 MHz clock for the whole run
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count rising edges so the scoreboard can check out_valid latency
   always @(posedge clock) cyc <= cyc + 1;

   // Hard stop in case some wait is never satisfied
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Every out_valid pulse must match the oldest expectation in the scoreboard
   always @(negedge clock) begin
      if (reset_n && out_valid) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
         end else begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput("lap_out", 64'(lap_out), 64'(e.lap));
            checkOutput("lap_index", 64'(lap_index), 64'(e.idx));
            checkOutput("valid_latency", 64'(cyc), 64'(e.due));
         end
      end
   end

   // Drive one request for a single rising edge, then count how long busy stays high
   task automatic applyStimulus(input logic s, input logic r, input logic c, input logic [WIDTH-1:0] t,
                                input logic expValid, input logic [WIDTH-1:0] expLap, input int expIdx,
                                output int busyCycles);
      exp_t e;
      @(negedge clock);
      if (expValid) begin
         e.lap = expLap;
         e.idx = CW'(expIdx);
         e.due = cyc + 3;
         sbq.push_back(e);
      end
      save     = s;
      retrieve = r;
      clear    = c;
      time_in  = t;
      @(negedge clock);
      save     = 1'b0;
      retrieve = 1'b0;
      clear    = 1'b0;
      busyCycles = 0;
      while (busy && busyCycles < 40) begin
         busyCycles++;
         @(negedge clock);
      end
   endtask

   function automatic vec_t makeVec(logic s, logic r, logic c, logic [WIDTH-1:0] t, int eb, int ec,
                                    logic ee, logic ef, logic ev, logic [WIDTH-1:0] el, int ei);
      vec_t v;
      v.s = s; v.r = r; v.c = c; v.t = t;
      v.expBusy = eb; v.expCount = ec; v.expEmpty = ee; v.expFull = ef;
      v.expValid = ev; v.expLap = el; v.expIdx = ei;
      return v;
   endfunction

   // Main test sequence
   initial begin
      int bc;
      logic [WIDTH-1:0] expVal;

      vecs.push_back(makeVec(0, 1, 0, 28'h0,       0, 0, 1, 0, 0, 28'h0,       0));
      vecs.push_back(makeVec(1, 0, 0, 28'h0000001, 1, 1, 0, 0, 0, 28'h0,       0));
      vecs.push_back(makeVec(1, 0, 0, 28'h0041064, 1, 2, 0, 0, 0, 28'h0,       0));
      vecs.push_back(makeVec(1, 0, 0, 28'h3FFFFFF, 1, 3, 0, 0, 0, 28'h0,       0));
      vecs.push_back(makeVec(0, 1, 0, 28'h0,       2, 3, 0, 0, 1, 28'h0000001, 1));
      vecs.push_back(makeVec(0, 1, 0, 28'h0,       2, 3, 0, 0, 1, 28'h0041064, 2));
      vecs.push_back(makeVec(0, 1, 0, 28'h0,       2, 3, 0, 0, 1, 28'h3FFFFFF, 3));
      vecs.push_back(makeVec(0, 1, 0, 28'h0,       2, 3, 0, 0, 1, 28'h0000001, 1));
      vecs.push_back(makeVec(1, 1, 0, 28'h1234567, 1, 4, 0, 0, 0, 28'h0,       0));
      vecs.push_back(makeVec(0, 1, 0, 28'h0,       2, 4, 0, 0, 1, 28'h0041064, 2));
      vecs.push_back(makeVec(0, 1, 0, 28'h0,       2, 4, 0, 0, 1, 28'h3FFFFFF, 3));
      vecs.push_back(makeVec(0, 1, 0, 28'h0,       2, 4, 0, 0, 1, 28'h1234567, 4));
      vecs.push_back(makeVec(1, 0, 0, 28'h0000ABC, 1, 5, 0, 0, 0, 28'h0,       0));

      reset_n  = 1'b0;
      save     = 1'b0;
      retrieve = 1'b0;
      clear    = 1'b0;
      time_in  = '0;
      #12;
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_lap_out", 64'(lap_out), 64'(0));
      checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset_lap_index", 64'(lap_index), 64'(0));
      checkOutput("reset_count", 64'(count), 64'(0));
      checkOutput("reset_empty", 64'(empty), 64'(1));
      checkOutput("reset_full", 64'(full), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].t,
                       vecs[i].expValid, vecs[i].expLap, vecs[i].expIdx, bc);
         checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].expCount));
         checkOutput($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].expEmpty));
         checkOutput($sformatf("vec%0d_full", i), 64'(full), 64'(vecs[i].expFull));
      end

      // Clear holding five laps, with a save pulsed while the clear is running
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      bc = 0;
      while (busy && bc < 40) begin
         bc++;
         save    = (bc == 3);
         time_in = 28'h0BADBAD;
         @(negedge clock);
      end
      save = 1'b0;
      checkOutput("clear_busy_cycles", 64'(bc), 64'(DEPTH));
      checkOutput("clear_count", 64'(count), 64'(0));
      checkOutput("clear_empty", 64'(empty), 64'(1));
      checkOutput("clear_lap_out", 64'(lap_out), 64'(0));
      checkOutput("clear_lap_index", 64'(lap_index), 64'(0));
      repeat (2) @(negedge clock);
      checkOutput("clear_save_dropped", 64'(count), 64'(0));

      // Nine saves into an eight-entry bank
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, WIDTH'(k), 1'b0, '0, 0, bc);
`ifdef LAP_OVERWRITE_EN
         checkOutput($sformatf("fill%0d_busy", k), 64'(bc), 64'(1));
`else
         checkOutput($sformatf("fill%0d_busy", k), 64'(bc), 64'((k <= DEPTH) ? 1 : 0));
`endif
      end
      checkOutput("fill_count", 64'(count), 64'(DEPTH));
      checkOutput("fill_full", 64'(full), 64'(1));
      checkOutput("fill_empty", 64'(empty), 64'(0));
      for (int k = 1; k <= 9; k++) begin
`ifdef LAP_OVERWRITE_EN
         expVal = WIDTH'(((k - 1) % DEPTH) + 2);
`else
         expVal = WIDTH'(((k - 1) % DEPTH) + 1);
`endif
         applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, expVal, ((k - 1) % DEPTH) + 1, bc);
         checkOutput($sformatf("wrap%0d_busy", k), 64'(bc), 64'(2));
      end

      // Reset asserted during the third cycle of a clear
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      repeat (2) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", 64'(busy), 64'(0));
      checkOutput("abort_lap_out", 64'(lap_out), 64'(0));
      checkOutput("abort_lap_index", 64'(lap_index), 64'(0));
      checkOutput("abort_count", 64'(count), 64'(0));
      checkOutput("abort_empty", 64'(empty), 64'(1));
      checkOutput("abort_full", 64'(full), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 28'h0ABCDEF, 1'b0, '0, 0, bc);
      checkOutput("abort_save_busy", 64'(bc), 64'(1));
      checkOutput("abort_save_count", 64'(count), 64'(1));
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1, 28'h0ABCDEF, 1, bc);
      checkOutput("abort_retrieve_busy", 64'(bc), 64'(2));

      repeat (3) @(negedge clock);
      checkOutput("scoreboard_drained", 64'(sbq.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
